// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - issue/sequencing controller feeding a combinational ALU
//
// Purpose: accepts one instruction word, reads its operands from an internal
// 8x32 register file and presents them to the external ALU. It then samples the
// ALU result and flags, writes the result back and holds the flags for branch logic.
// Sequence is IDLE -> READ -> EXEC -> WB, so one instruction completes every 4 cycles.
//
// Ports:
//   CLK, RST               clock (rising edge), synchronous active-high reset
//   INSTR, INSTR_VALID     instruction word and its valid
//   INSTR_READY            high only in IDLE
//   ALU_IN1/IN2/SRA/SEL    registered operands / shift amount / opcode to the ALU
//   ALU_OUT, ALU_FLAGS     combinational ALU result and {Z,S,P,G,E,L}
//   RESULT, FLAGS          last written-back result / last latched flags
//   DONE, ERR              completion pulse / divide-by-zero pulse (with DONE)
//   BUSY                   instruction in flight
//   DBG_ADDR, DBG_DATA     combinational register-file debug read

module alu_issue_ctrl #(
  parameter bit IMM_SIGN  = 1'b0,
  parameter bit DIV0_TRAP = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] INSTR,
  input  logic        INSTR_VALID,
  output logic        INSTR_READY,
  output logic [31:0] ALU_IN1,
  output logic [31:0] ALU_IN2,
  output logic [4:0]  ALU_SRA,
  output logic [3:0]  ALU_SEL,
  input  logic [31:0] ALU_OUT,
  input  logic [5:0]  ALU_FLAGS,
  output logic [31:0] RESULT,
  output logic [5:0]  FLAGS,
  output logic        DONE,
  output logic        ERR,
  output logic        BUSY,
  input  logic [2:0]  DBG_ADDR,
  output logic [31:0] DBG_DATA
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

  logic [1:0]  state;
  logic [31:0] instr_q;
  logic [31:0] regs [8];
  logic        err_q;

  // Decoded fields of the latched instruction
  logic [3:0]  f_sel;
  logic [2:0]  f_rd;
  logic [2:0]  f_rs1;
  logic [2:0]  f_rs2;
  logic [4:0]  f_sra;
  logic        f_imm;
  logic        f_nowb;
  logic [11:0] f_imm12;

  assign f_sel   = instr_q[31:28];
  assign f_rd    = instr_q[27:25];
  assign f_rs1   = instr_q[24:22];
  assign f_rs2   = instr_q[21:19];
  assign f_sra   = instr_q[18:14];
  assign f_imm   = instr_q[13];
  assign f_nowb  = instr_q[12];
  assign f_imm12 = instr_q[11:0];

  logic [31:0] imm_ext;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        div0;

  assign imm_ext = IMM_SIGN ? {{20{f_imm12[11]}}, f_imm12} : {20'd0, f_imm12};

  // R0 is hard-wired to zero on every read path
  assign rs1_val  = (f_rs1 == 3'd0)    ? 32'd0 : regs[f_rs1];
  assign rs2_val  = (f_rs2 == 3'd0)    ? 32'd0 : regs[f_rs2];
  assign DBG_DATA = (DBG_ADDR == 3'd0) ? 32'd0 : regs[DBG_ADDR];

  // Evaluated on the registered ALU inputs while in EXEC
  assign div0 = DIV0_TRAP && ((ALU_SEL == 4'b0011) || (ALU_SEL == 4'b0100)) &&
                (ALU_IN2 == 32'd0);

  assign INSTR_READY = (state == S_IDLE);
  assign BUSY        = (state != S_IDLE);
  assign DONE        = (state == S_WB);
  assign ERR         = (state == S_WB) && err_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_IDLE;
      instr_q <= 32'd0;
      ALU_IN1 <= 32'd0;
      ALU_IN2 <= 32'd0;
      ALU_SRA <= 5'd0;
      ALU_SEL <= 4'd0;
      RESULT  <= 32'd0;
      FLAGS   <= 6'd0;
      err_q   <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        regs[i] <= 32'd0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (INSTR_VALID) begin
            instr_q <= INSTR;
            state   <= S_READ;
          end
        end
        S_READ: begin
          ALU_IN1 <= rs1_val;
          ALU_IN2 <= f_imm ? imm_ext : rs2_val;
          ALU_SRA <= f_sra;
          ALU_SEL <= f_sel;
          state   <= S_EXEC;
        end
        S_EXEC: begin
          // The ALU output is sampled straight into RESULT/FLAGS and the
          // register file here, so the WB cycle (DONE high) already shows the
          // written-back values and the next READ sees them.
          err_q <= div0;
          if (div0) begin
            RESULT <= 32'd0;
          end else begin
            RESULT <= ALU_OUT;
            FLAGS  <= ALU_FLAGS;
            if (!f_nowb && (f_rd != 3'd0)) begin
              regs[f_rd] <= ALU_OUT;
            end
          end
          state <= S_WB;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
